// File: rtl/opb_register_simulink2ppc_snap_pkg.sv
// Shared definitions for the simulink->PPC snapshot register core.
// Holds the word offsets, the STATUS and CTRL bit positions, and the state
// encoding of the OPB acknowledge FSM.
package opb_register_simulink2ppc_snap_pkg;

    // Word index decoded from ABus[28:29]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // STATUS bit positions
    localparam int FRESH   = 0;
    localparam int OVR     = 1;
    localparam int CNT_LSB = 16;

    // CTRL bit positions
    localparam int CLR = 0;
    localparam int FRZ = 1;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } ack_state_t;

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// Generic OPB slave front end: address decode, single-cycle acknowledge FSM
// and OR-bus read-data gating.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   abus/be/dbus/rnw/select   OPB request (big-endian bit numbering)
//   offset          combinational word index of the current address
//   rd_word         register value for 'offset', sampled on the hit cycle
//   sl_dbus         read data, non-zero only in the ACK cycle of a read
//   xfer_ack        transfer acknowledge
//   wr_stb/rd_stb   ACK cycle of a write / read
//   ack_off, ack_wdata, ack_be   request fields captured on the hit cycle
module opb_slave_ack_fsm #(
    parameter logic [31:0] BASEADDR = 32'h0100_0700,
    parameter logic [31:0] HIGHADDR = 32'h0100_07FF,
    parameter int          AW       = 32,
    parameter int          DW       = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [0:AW-1] abus,
    input  logic [0:3]    be,
    input  logic [0:DW-1] dbus,
    input  logic          rnw,
    input  logic          select,
    output logic [1:0]    offset,
    input  logic [DW-1:0] rd_word,
    output logic [0:DW-1] sl_dbus,
    output logic          xfer_ack,
    output logic          wr_stb,
    output logic          rd_stb,
    output logic [1:0]    ack_off,
    output logic [DW-1:0] ack_wdata,
    output logic [0:3]    ack_be
);
    import opb_register_simulink2ppc_snap_pkg::*;

    ack_state_t    state, state_nxt;
    logic          hit;
    logic          rnw_q;
    logic [DW-1:0] rd_q;

    assign hit    = select && (abus >= BASEADDR) && (abus <= HIGHADDR);
    assign offset = abus[AW-4:AW-3];

    // Only IDLE can accept a hit, and ACK always returns to IDLE, so a
    // select held high is acked every other cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hit) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rnw_q     <= 1'b0;
            rd_q      <= '0;
            ack_off   <= '0;
            ack_wdata <= '0;
            ack_be    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && hit) begin
                rnw_q     <= rnw;
                rd_q      <= rd_word;
                ack_off   <= offset;
                ack_wdata <= dbus;
                ack_be    <= be;
            end
        end
    end

    assign xfer_ack = (state == ACK);
    assign rd_stb   = xfer_ack &&  rnw_q;
    assign wr_stb   = xfer_ack && !rnw_q;
    // Shared OR-bus: drive zero whenever we are not returning read data.
    assign sl_dbus  = rd_stb ? rd_q : '0;

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// OPB register core, fabric-to-PPC direction. Latches the last word pushed by
// fabric logic and reports fresh / overrun / update count so software can tell
// which updates it has seen.
// Ports:
//   OPB_*            OPB slave request (DBus[0] is the MSB)
//   Sl_*             OPB slave response; errAck/retry/toutSup tied low
//   user_data_in     fabric word, captured when user_valid=1 and not frozen
//   user_valid       single-cycle capture strobe
//   user_freeze      CTRL.freeze, for fabric flow control
module opb_register_simulink2ppc_snap #(
    parameter logic [31:0] C_BASEADDR   = 32'h0100_0700,
    parameter logic [31:0] C_HIGHADDR   = 32'h0100_07FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic                    Sl_xferAck,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid,
    output logic                    user_freeze
);
    import opb_register_simulink2ppc_snap_pkg::*;

    localparam int DW = C_OPB_DWIDTH;

    logic [1:0]    offset;
    logic [DW-1:0] rd_word;
    logic          wr_stb, rd_stb;
    logic [1:0]    ack_off;
    logic [DW-1:0] ack_wdata;
    logic [0:3]    ack_be;

    logic [31:0]   data_q;
    logic          fresh, overrun, freeze;
    logic [15:0]   count;

    logic          capture, data_rd, ctrl_wr, clr;

    opb_slave_ack_fsm #(
        .BASEADDR (C_BASEADDR),
        .HIGHADDR (C_HIGHADDR),
        .AW       (C_OPB_AWIDTH),
        .DW       (DW)
    ) u_ack (
        .clk       (OPB_Clk),
        .rst       (OPB_Rst),
        .abus      (OPB_ABus),
        .be        (OPB_BE),
        .dbus      (OPB_DBus),
        .rnw       (OPB_RNW),
        .select    (OPB_select),
        .offset    (offset),
        .rd_word   (rd_word),
        .sl_dbus   (Sl_DBus),
        .xfer_ack  (Sl_xferAck),
        .wr_stb    (wr_stb),
        .rd_stb    (rd_stb),
        .ack_off   (ack_off),
        .ack_wdata (ack_wdata),
        .ack_be    (ack_be)
    );

    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_freeze = freeze;

    // Read mux; CTRL.clear is self-clearing so it always reads back 0.
    always_comb begin
        rd_word = '0;
        case (offset)
            REG_DATA: rd_word = data_q;
            REG_STATUS: begin
                rd_word[FRESH]             = fresh;
                rd_word[OVR]               = overrun;
                rd_word[CNT_LSB +: 16]     = count;
            end
            REG_CTRL: rd_word[FRZ] = freeze;
            default:  rd_word = '0;
        endcase
    end

    assign capture = user_valid && !freeze;
    assign data_rd = rd_stb && (ack_off == REG_DATA);
    assign ctrl_wr = wr_stb && (ack_off == REG_CTRL) && ack_be[3];
    assign clr     = ctrl_wr && ack_wdata[CLR];

    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            data_q  <= '0;
            fresh   <= 1'b0;
            overrun <= 1'b0;
            count   <= '0;
            freeze  <= 1'b0;
        end else begin
            if (capture) data_q <= user_data_in;

            // A capture in the same cycle as a DATA read keeps fresh set.
            if (capture)      fresh <= 1'b1;
            else if (data_rd) fresh <= 1'b0;

            // Clear dominates; a read completing now counts as having seen
            // the old word, so it is not an overrun.
            if (clr)                               overrun <= 1'b0;
            else if (capture && fresh && !data_rd) overrun <= 1'b1;

            if (clr)          count <= capture ? 16'd1 : 16'd0;
            else if (capture) count <= count + 16'd1;

            if (ctrl_wr) freeze <= ack_wdata[FRZ];
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, OPB_seqAddr, ack_wdata[DW-1:2], ack_be[0:2]};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE = 32'h0100_0700;

    logic        clk;
    logic        rst;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus_w;
    logic        rnw;
    logic        sel;
    logic        seq;
    logic [0:31] sl_dbus;
    logic        err_ack, retry, tout_sup, ack;
    logic [31:0] udata;
    logic        uvalid;
    logic        ufreeze;

    int checks = 0;
    int errors = 0;

    opb_register_simulink2ppc_snap dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .OPB_ABus     (abus),
        .OPB_BE       (be),
        .OPB_DBus     (dbus_w),
        .OPB_RNW      (rnw),
        .OPB_select   (sel),
        .OPB_seqAddr  (seq),
        .Sl_DBus      (sl_dbus),
        .Sl_errAck    (err_ack),
        .Sl_retry     (retry),
        .Sl_toutSup   (tout_sup),
        .Sl_xferAck   (ack),
        .user_data_in (udata),
        .user_valid   (uvalid),
        .user_freeze  (ufreeze)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the bus idle. Checks the one-cycle ack latency.
    task automatic opb_read(input logic [31:0] off, output logic [31:0] d);
        abus = BASE + off; rnw = 1'b1; sel = 1'b1;
        chk("rd_ack_hit_cycle", {31'b0, ack}, 32'd0);
        @(negedge clk);
        chk("rd_ack_latency", {31'b0, ack}, 32'd1);
        d = sl_dbus;
        sel = 1'b0; abus = '0; rnw = 1'b0;
        @(negedge clk);
        chk("rd_ack_drop", {31'b0, ack}, 32'd0);
        chk("rd_dbus_idle", sl_dbus, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] d;
        opb_read(off, d);
        chk(tag, d, exp);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d, input logic [0:3] b);
        abus = BASE + off; rnw = 1'b0; sel = 1'b1; dbus_w = d; be = b;
        chk("wr_ack_hit_cycle", {31'b0, ack}, 32'd0);
        @(negedge clk);
        chk("wr_ack_latency", {31'b0, ack}, 32'd1);
        chk("wr_dbus_zero", sl_dbus, 32'd0);
        sel = 1'b0; abus = '0; dbus_w = '0; be = '0;
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] d);
        udata = d; uvalid = 1'b1;
        @(negedge clk);
        uvalid = 1'b0; udata = '0;
    endtask

    initial begin
        logic [31:0] d;
        rst = 1'b1; abus = '0; be = '0; dbus_w = '0; rnw = 1'b0; sel = 1'b0;
        seq = 1'b0; udata = '0; uvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ack", {31'b0, ack}, 32'd0);
        chk("reset_dbus", sl_dbus, 32'd0);
        chk("reset_freeze", {31'b0, ufreeze}, 32'd0);
        chk("tied_outputs", {29'b0, err_ack, retry, tout_sup}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        rd("reset_data",   32'h0, 32'h0000_0000);
        rd("reset_status", 32'h4, 32'h0000_0000);
        rd("reset_ctrl",   32'h8, 32'h0000_0000);

        // Single capture, then DATA read clears fresh
        push(32'hDEAD_BEEF);
        rd("status_after_push", 32'h4, 32'h0001_0001);
        rd("data_deadbeef",     32'h0, 32'hDEAD_BEEF);
        rd("status_after_read", 32'h4, 32'h0001_0000);
        rd("unmapped_0c",       32'hC, 32'h0000_0000);

        // Clear count, then two pushes without a read -> overrun
        wr(32'h8, 32'h0000_0001, 4'b1111);
        push(32'h1);
        push(32'h2);
        rd("status_overrun", 32'h4, 32'h0002_0003);
        rd("data_second",    32'h0, 32'h0000_0002);
        push(32'h3);
        wr(32'h8, 32'h0000_0001, 4'b1111);
        rd("status_after_clr", 32'h4, 32'h0000_0001);
        rd("ctrl_clr_reads0",  32'h8, 32'h0000_0000);
        rd("data_after_clr",   32'h0, 32'h0000_0003);

        // Freeze: captures ignored
        wr(32'h8, 32'h0000_0002, 4'b1111);
        chk("freeze_on", {31'b0, ufreeze}, 32'd1);
        rd("ctrl_freeze", 32'h8, 32'h0000_0002);
        push(32'h55);
        rd("data_frozen",   32'h0, 32'h0000_0003);
        rd("status_frozen", 32'h4, 32'h0000_0000);
        wr(32'h8, 32'h0000_0000, 4'b1111);
        chk("freeze_off", {31'b0, ufreeze}, 32'd0);
        // BE[3]=0: acked, no effect
        wr(32'h8, 32'h0000_0002, 4'b1110);
        chk("ctrl_be3_low", {31'b0, ufreeze}, 32'd0);

        // Capture in the ACK cycle of a DATA read
        push(32'h11);
        abus = BASE; rnw = 1'b1; sel = 1'b1;
        @(negedge clk);
        chk("race_ack", {31'b0, ack}, 32'd1);
        d = sl_dbus;
        udata = 32'hAA; uvalid = 1'b1;
        sel = 1'b0; abus = '0; rnw = 1'b0;
        @(negedge clk);
        uvalid = 1'b0; udata = '0;
        chk("race_read_old", d, 32'h0000_0011);
        rd("race_status", 32'h4, 32'h0002_0001);
        rd("race_data",   32'h0, 32'h0000_00AA);

        // Out-of-range address: never acked
        abus = BASE + 32'h100; rnw = 1'b1; sel = 1'b1;
        @(negedge clk);
        chk("miss_ack1", {31'b0, ack}, 32'd0);
        @(negedge clk);
        chk("miss_ack2", {31'b0, ack}, 32'd0);
        sel = 1'b0; abus = '0; rnw = 1'b0;
        @(negedge clk);

        // Select held for 4 cycles: ack in cycles 2 and 4 only
        abus = BASE + 32'h4; rnw = 1'b1; sel = 1'b1;
        chk("hold_c1", {31'b0, ack}, 32'd0);
        @(negedge clk);
        chk("hold_c2", {31'b0, ack}, 32'd1);
        @(negedge clk);
        chk("hold_c3", {31'b0, ack}, 32'd0);
        chk("hold_c3_dbus", sl_dbus, 32'd0);
        @(negedge clk);
        chk("hold_c4", {31'b0, ack}, 32'd1);
        sel = 1'b0; abus = '0; rnw = 1'b0;
        @(negedge clk);
        chk("hold_c5", {31'b0, ack}, 32'd0);

        // Reset during the hit cycle drops the transfer and clears state
        wr(32'h8, 32'h0000_0002, 4'b1111);
        chk("pre_rst_freeze", {31'b0, ufreeze}, 32'd1);
        abus = BASE; rnw = 1'b1; sel = 1'b1; rst = 1'b1;
        #1;
        chk("rst_hit_ack", {31'b0, ack}, 32'd0);
        @(negedge clk);
        chk("rst_no_ack", {31'b0, ack}, 32'd0);
        chk("rst_dbus", sl_dbus, 32'd0);
        chk("rst_freeze", {31'b0, ufreeze}, 32'd0);
        sel = 1'b0; abus = '0; rnw = 1'b0; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ack", {31'b0, ack}, 32'd0);
        rd("post_rst_status", 32'h4, 32'h0000_0000);
        rd("post_rst_data",   32'h0, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
